// File: rtl/game_over_sequencer_if.sv
// Game-state phase handshake between the top-level state FSM (master) and
// the game-over screen sequencer (slave). Carries the raster position used
// for the frame strobe, the game state, the confirm button and the sprite
// control outputs.
interface game_over_sequencer_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [3:0]  state_in;
    logic        decide_in;
    logic        busy_out;
    logic        finished_out;
    logic [2:0]  phase_out;
    logic        divided_out;
    logic        fall_apart_valid_out;
    logic [11:0] font_color_out;

    // Top-level FSM / video timing side
    modport master (
        output hcount_in, vcount_in, state_in, decide_in,
        input  busy_out, finished_out, phase_out, divided_out,
               fall_apart_valid_out, font_color_out
    );

    // Game-over sequencer side
    modport slave (
        input  hcount_in, vcount_in, state_in, decide_in,
        output busy_out, finished_out, phase_out, divided_out,
               fall_apart_valid_out, font_color_out
    );
endinterface

// File: rtl/game_over_sequencer.sv
// game_over_sequencer: runs the game-over screen timeline
//   heart idle -> heart split -> shards fall -> text fade -> hold
// and waits for the player to dismiss the screen with a fresh press of the
// confirm button. Reports busy/finished to the top-level state FSM.
//
// Optional feature macro: GAME_OVER_SKIP_EN
//   defined   : a decide edge during IDLE/SPLIT/FALL/FADE jumps straight to HOLD
//   undefined : decide_in only matters in HOLD
//
// Every output is a register loaded from the current FSM state, so outputs
// trail the internal state by one clock. Phase durations are unaffected.
module game_over_sequencer #(
    parameter logic [3:0]  ACTIVE_STATE = 4'b1111,
    parameter int unsigned IDLE_CYCLES  = 65000000,
    parameter int unsigned SPLIT_CYCLES = 130000000,
    parameter int unsigned FALL_CYCLES  = 130000000,
    parameter int unsigned FADE_FRAMES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    game_over_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_SPLIT = 3'd2,
        S_FALL  = 3'd3,
        S_FADE  = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Terminal counts, precomputed at the counter widths
    localparam logic [31:0] IDLE_LAST  = 32'(IDLE_CYCLES - 1);
    localparam logic [31:0] SPLIT_LAST = 32'(SPLIT_CYCLES - 1);
    localparam logic [31:0] FALL_LAST  = 32'(FALL_CYCLES - 1);
    localparam logic [7:0]  FADE_LAST  = 8'(FADE_FRAMES - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] cnt;
    logic [7:0]  frame_cnt;
    logic [3:0]  nib;
    logic        act_prev;
    logic        decide_prev;

    logic        act;
    logic        start;
    logic        decide_edge;
    logic        skip_edge;
    logic        strobe;
    logic        fade_step;
    logic        fade_end;

    // Registered outputs and their next values
    logic        busy_q,     busy_d;
    logic        finished_q, finished_d;
    logic [2:0]  phase_q,    phase_d;
    logic        divided_q,  divided_d;
    logic        fav_q,      fav_d;
    logic [11:0] color_q,    color_d;

    assign act         = (bus.state_in == ACTIVE_STATE);
    assign start       = act && !act_prev;
    assign decide_edge = bus.decide_in && !decide_prev;
    assign strobe      = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

    // One nibble step per FADE_FRAMES strobes; the step that makes n reach F
    // ends the fade.
    assign fade_step   = strobe && (frame_cnt == FADE_LAST);
    assign fade_end    = fade_step && (nib == 4'hE);

`ifdef GAME_OVER_SKIP_EN
    assign skip_edge   = decide_edge;
`else
    assign skip_edge   = 1'b0;
`endif

    // Edge-detector history, tracked every cycle regardless of state
    always_ff @(posedge clk) begin
        if (rst) begin
            act_prev    <= 1'b0;
            decide_prev <= 1'b0;
        end else begin
            act_prev    <= act;
            decide_prev <= bus.decide_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_WAIT;
        else
            state <= state_nx;
    end

    // FSM next-state logic; losing the active game state beats everything
    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT: begin
                if (start)
                    state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (!act)                   state_nx = S_WAIT;
                else if (skip_edge)         state_nx = S_HOLD;
                else if (cnt == IDLE_LAST)  state_nx = S_SPLIT;
            end
            S_SPLIT: begin
                if (!act)                   state_nx = S_WAIT;
                else if (skip_edge)         state_nx = S_HOLD;
                else if (cnt == SPLIT_LAST) state_nx = S_FALL;
            end
            S_FALL: begin
                if (!act)                   state_nx = S_WAIT;
                else if (skip_edge)         state_nx = S_HOLD;
                else if (cnt == FALL_LAST)  state_nx = S_FADE;
            end
            S_FADE: begin
                if (!act)                   state_nx = S_WAIT;
                else if (skip_edge)         state_nx = S_HOLD;
                else if (fade_end)          state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (!act)                   state_nx = S_WAIT;
                else if (decide_edge)       state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_WAIT;
            end
            default: begin
                state_nx = S_WAIT;
            end
        endcase
    end

    // Cycle counter restarts from zero on every state entry
    always_ff @(posedge clk) begin
        if (rst || (state_nx != state))
            cnt <= 32'd0;
        else
            cnt <= cnt + 32'd1;
    end

    // Frame counter and colour nibble only run inside FADE, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst || (state != S_FADE)) begin
            frame_cnt <= 8'd0;
            nib       <= 4'h0;
        end else if (strobe) begin
            if (frame_cnt == FADE_LAST) begin
                frame_cnt <= 8'd0;
                nib       <= nib + 4'h1;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // FSM output decode from the current state
    always_comb begin
        busy_d     = 1'b0;
        finished_d = 1'b0;
        phase_d    = 3'd0;
        divided_d  = 1'b0;
        fav_d      = 1'b0;
        color_d    = 12'h000;
        case (state)
            S_IDLE: begin
                busy_d    = 1'b1;
            end
            S_SPLIT: begin
                busy_d    = 1'b1;
                phase_d   = 3'd1;
                divided_d = 1'b1;
            end
            S_FALL: begin
                busy_d    = 1'b1;
                phase_d   = 3'd2;
                divided_d = 1'b1;
                fav_d     = 1'b1;
            end
            S_FADE: begin
                busy_d    = 1'b1;
                phase_d   = 3'd3;
                divided_d = 1'b1;
                fav_d     = 1'b1;
                color_d   = {nib, nib, nib};
            end
            S_HOLD: begin
                busy_d    = 1'b1;
                phase_d   = 3'd3;
                divided_d = 1'b1;
                fav_d     = 1'b1;
                color_d   = 12'hFFF;
            end
            S_DONE: begin
                finished_d = 1'b1;
                phase_d    = 3'd3;
                divided_d  = 1'b1;
                fav_d      = 1'b1;
                color_d    = 12'hFFF;
            end
            default: begin
                busy_d     = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            phase_q    <= 3'd0;
            divided_q  <= 1'b0;
            fav_q      <= 1'b0;
            color_q    <= 12'h000;
        end else begin
            busy_q     <= busy_d;
            finished_q <= finished_d;
            phase_q    <= phase_d;
            divided_q  <= divided_d;
            fav_q      <= fav_d;
            color_q    <= color_d;
        end
    end

    assign bus.busy_out             = busy_q;
    assign bus.finished_out         = finished_q;
    assign bus.phase_out            = phase_q;
    assign bus.divided_out          = divided_q;
    assign bus.fall_apart_valid_out = fav_q;
    assign bus.font_color_out       = color_q;

endmodule
